// File: rtl/led_pattern_sequencer.sv
// LED bar sequencer: clk divider produces pattern steps; mode FSM selects one of five patterns.
// Latency: first step lands DIVIDER edges after reset/mode change; all outputs registered.
// Backpressure: none; pause freezes divider and pattern, mode_next always honoured.
// Optional auto mode advance after AUTO_STEPS steps: define LED_SEQ_AUTO_CYCLE_EN.
module led_pattern_sequencer #(
    parameter int DIVIDER    = 4,
    parameter int AUTO_STEPS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_next,
    input  logic       pause,
    output logic [7:0] led,
    output logic [2:0] mode,
    output logic       step_tick
);

    localparam int DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        MODE_SHL    = 3'd0,
        MODE_SHR    = 3'd1,
        MODE_BOUNCE = 3'd2,
        MODE_BLINK  = 3'd3,
        MODE_COUNT  = 3'd4
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [7:0]       led_q, led_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             step_tick_q, step_tick_d;
    logic             dir_q, dir_d;

    logic [7:0]       step_led;
    logic             step_dir;
    logic             step_edge;

`ifdef LED_SEQ_AUTO_CYCLE_EN
    localparam int AUTO_W = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_STEPS - 1);
    logic [AUTO_W-1:0] step_cnt_q, step_cnt_d;
`endif

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_SHL:    return MODE_SHR;
            MODE_SHR:    return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_BLINK;
            MODE_BLINK:  return MODE_COUNT;
            default:     return MODE_SHL;
        endcase
    endfunction

    function automatic logic [7:0] mode_seed(input mode_e m);
        case (m)
            MODE_SHR:   return 8'h80;
            MODE_BLINK: return 8'hFF;
            MODE_COUNT: return 8'h00;
            default:    return 8'h01;
        endcase
    endfunction

    assign step_edge = !pause && (div_cnt_q == DIV_LAST);

    // Next pattern value if this edge turns out to be a plain step.
    always_comb begin
        step_led = led_q;
        step_dir = dir_q;
        case (mode_q)
            MODE_SHL:    step_led = {led_q[6:0], led_q[7]};
            MODE_SHR:    step_led = {led_q[0], led_q[7:1]};
            MODE_BOUNCE: begin
                if (led_q == 8'h80) begin
                    step_led = 8'h40;
                    step_dir = DIR_RIGHT;
                end else if (led_q == 8'h01) begin
                    step_led = 8'h02;
                    step_dir = DIR_LEFT;
                end else if (dir_q == DIR_LEFT) begin
                    step_led = {led_q[6:0], 1'b0};
                end else begin
                    step_led = {1'b0, led_q[7:1]};
                end
            end
            MODE_BLINK:  step_led = ~led_q;
            MODE_COUNT:  step_led = led_q + 8'd1;
            default:     step_led = led_q;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        led_d       = led_q;
        div_cnt_d   = div_cnt_q;
        step_tick_d = 1'b0;
        dir_d       = dir_q;
`ifdef LED_SEQ_AUTO_CYCLE_EN
        step_cnt_d  = step_cnt_q;
`endif
        if (mode_q > MODE_COUNT) begin
            mode_d    = MODE_SHL;
            led_d     = 8'h01;
            div_cnt_d = '0;
            dir_d     = DIR_LEFT;
`ifdef LED_SEQ_AUTO_CYCLE_EN
            step_cnt_d = '0;
`endif
        end else if (mode_next) begin
            // Explicit advance beats any coincident step or auto advance.
            mode_d    = next_mode(mode_q);
            led_d     = mode_seed(next_mode(mode_q));
            div_cnt_d = '0;
            dir_d     = DIR_LEFT;
`ifdef LED_SEQ_AUTO_CYCLE_EN
            step_cnt_d = '0;
`endif
        end else if (step_edge) begin
            div_cnt_d   = '0;
            step_tick_d = 1'b1;
`ifdef LED_SEQ_AUTO_CYCLE_EN
            if (step_cnt_q == AUTO_LAST) begin
                mode_d     = next_mode(mode_q);
                led_d      = mode_seed(next_mode(mode_q));
                dir_d      = DIR_LEFT;
                step_cnt_d = '0;
            end else begin
                led_d      = step_led;
                dir_d      = step_dir;
                step_cnt_d = step_cnt_q + 1'b1;
            end
`else
            led_d = step_led;
            dir_d = step_dir;
`endif
        end else if (!pause) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_SHL;
            led_q       <= 8'h01;
            div_cnt_q   <= '0;
            step_tick_q <= 1'b0;
            dir_q       <= DIR_LEFT;
`ifdef LED_SEQ_AUTO_CYCLE_EN
            step_cnt_q  <= '0;
`endif
        end else begin
            mode_q      <= mode_d;
            led_q       <= led_d;
            div_cnt_q   <= div_cnt_d;
            step_tick_q <= step_tick_d;
            dir_q       <= dir_d;
`ifdef LED_SEQ_AUTO_CYCLE_EN
            step_cnt_q  <= step_cnt_d;
`endif
        end
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign step_tick = step_tick_q;

endmodule
